// File: rtl/alu_result_writer.sv
// alu_result_writer: latches ALU result words and writes the masked ones to memory over a shared bus
module alu_result_writer #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_oe,
   input  logic              start,
   input  logic [3:0]        wr_mask,
   input  logic [DATA_W-1:0] dst_in,
   input  logic [DATA_W-1:0] dst_h_in,
   input  logic [DATA_W-1:0] src0_in,
   input  logic [DATA_W-1:0] src1_in,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W-1:0] dst_h_addr,
   input  logic [ADDR_W-1:0] src0_addr,
   input  logic [ADDR_W-1:0] src1_addr,
   input  logic              is_bus_busy,
   input  logic              bus_ack,
   output logic              bus_req,
   output logic              bus_write,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_data,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, ARB, WRITE, DONE} state_t;
   state_t            state, state_n;
   logic [3:0]        mask_r, mask_left;
   logic [1:0]        slot;
   logic [TW-1:0]     tcnt;
   logic [DATA_W-1:0] data_r [4];
   logic [ADDR_W-1:0] addr_r [4];
   logic              accept, acked, timed_out;

   function automatic logic [1:0] low_bit(input logic [3:0] m);
      return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
   endfunction

   // next state and per-edge events; ack beats timeout on the same edge
   always_comb begin
      state_n   = state;
      accept    = 1'b0;
      acked     = 1'b0;
      timed_out = 1'b0;
      mask_left = mask_r & ~(4'b0001 << slot);
      case (state)
         IDLE: if (start && !busy) begin
            accept  = 1'b1;
            state_n = (wr_mask == 4'b0) ? DONE : ARB;
         end
         ARB: state_n = is_bus_busy ? ARB : WRITE;
         WRITE: if (bus_ack) begin
            acked   = 1'b1;
            state_n = (mask_left == 4'b0) ? DONE : ARB;
         end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
            timed_out = 1'b1;
            state_n   = DONE;
         end
         default: state_n = IDLE;
      endcase
   end

   // state, latched job, timeout counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mask_r    <= '0;
         slot      <= '0;
         tcnt      <= '0;
         bus_req   <= 1'b0;
         bus_write <= 1'b0;
         bus_addr  <= '0;
         bus_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            data_r[i] <= '0;
            addr_r[i] <= '0;
         end
      end else if (clk_oe) begin
         state     <= state_n;
         busy      <= (state_n != IDLE) || (state == DONE);
         done      <= state == DONE;
         tcnt      <= (state == WRITE) ? tcnt + 1'b1 : '0;
         bus_req   <= state_n == WRITE;
         bus_write <= state_n == WRITE;
         bus_addr  <= (state_n == WRITE) ? addr_r[slot] : '0;
         bus_data  <= (state_n == WRITE) ? data_r[slot] : '0;
         if (accept) begin
            mask_r    <= wr_mask;
            slot      <= low_bit(wr_mask);
            err       <= 1'b0;
            data_r[0] <= dst_in;
            data_r[1] <= dst_h_in;
            data_r[2] <= src0_in;
            data_r[3] <= src1_in;
            addr_r[0] <= dst_addr;
            addr_r[1] <= dst_h_addr;
            addr_r[2] <= src0_addr;
            addr_r[3] <= src1_addr;
         end
         if (acked) begin
            mask_r <= mask_left;
            slot   <= low_bit(mask_left);
         end
         if (timed_out) begin
            mask_r <= '0;
            err    <= 1'b1;
         end
      end else begin
         done <= 1'b0;
         busy <= busy & ~done;
         if (state != WRITE) begin
            bus_req   <= 1'b0;
            bus_write <= 1'b0;
            bus_addr  <= '0;
            bus_data  <= '0;
         end
      end
   end
endmodule

// File: tb/tb_alu_result_writer.sv
// tb_alu_result_writer: scoreboard bench for the ALU result write-back stage
module tb_alu_result_writer;
   localparam int DW = 32;
   localparam int AW = 32;
   typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;

   logic clk = 0, rst = 1, clk_oe = 1, start = 0, is_bus_busy = 0, bus_ack = 0;
   logic [3:0] wr_mask = 0;
   logic [DW-1:0] dst_in = 0, dst_h_in = 0, src0_in = 0, src1_in = 0;
   logic [AW-1:0] dst_addr = 0, dst_h_addr = 0, src0_addr = 0, src1_addr = 0;
   logic bus_req, bus_write, busy, done, err;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_data;

   wr_t exp_q[$];
   int vectors = 0, miscompares = 0, done_cnt = 0, req_hi = 0, cyc = 0, t0 = 0;
   int ack_delay = 1, wc = 0;
   logic oe_tog = 0, ack_en = 1, prev_req = 0;

   alu_result_writer #(.DATA_W(DW), .ADDR_W(AW), .ACK_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .clk_oe(clk_oe), .start(start), .wr_mask(wr_mask),
      .dst_in(dst_in), .dst_h_in(dst_h_in), .src0_in(src0_in), .src1_in(src1_in),
      .dst_addr(dst_addr), .dst_h_addr(dst_h_addr), .src0_addr(src0_addr), .src1_addr(src1_addr),
      .is_bus_busy(is_bus_busy), .bus_ack(bus_ack), .bus_req(bus_req), .bus_write(bus_write),
      .bus_addr(bus_addr), .bus_data(bus_data), .busy(busy), .done(done), .err(err)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
      #1 clk_oe = oe_tog ? ~clk_oe : 1'b1;
   end

   // memory responder: ack after ack_delay enabled edges in WRITE
   initial forever begin
      @(negedge clk);
      if (!bus_req) begin
         wc = 0;
         bus_ack = 0;
      end else begin
         bus_ack = ack_en && (wc >= ack_delay);
         if (clk_oe) wc++;
      end
   end

   // monitor: each new bus write is checked against the scoreboard
   initial forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (bus_req) req_hi++;
      if (bus_req && !prev_req) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: got addr=%h data=%h, required no write", bus_addr, bus_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if ({bus_write, bus_addr, bus_data} !== {1'b1, e.a, e.d}) begin
               miscompares++;
               $display("FAIL write: got we=%b addr=%h data=%h, required we=1 addr=%h data=%h",
                        bus_write, bus_addr, bus_data, e.a, e.d);
            end
         end
      end
      prev_req = bus_req;
   end

   task automatic en_edge();
      do @(negedge clk); while (!clk_oe);
      @(posedge clk);
      #2;
   endtask

   task automatic fire(input logic [3:0] m, input logic [3:0] pm);
      wr_t w[4];
      en_edge();
      en_edge();
      w[0] = {dst_addr, dst_in};
      w[1] = {dst_h_addr, dst_h_in};
      w[2] = {src0_addr, src0_in};
      w[3] = {src1_addr, src1_in};
      for (int i = 0; i < 4; i++) if (pm[i]) exp_q.push_back(w[i]);
      wr_mask = m;
      start = 1;
      en_edge();
      t0 = cyc;
      start = 0;
   endtask

   task automatic wait_done(output int lat, output int clks);
      lat = -1;
      clks = -1;
      for (int k = 1; k <= 300; k++) begin
         en_edge();
         if (done) begin
            lat = k;
            clks = cyc - t0;
            break;
         end
      end
      if (lat < 0) begin
         vectors++;
         miscompares++;
         $display("FAIL done_wait: no done within 300 enabled cycles");
      end
   endtask

   task automatic set_words(input logic [DW-1:0] b);
      dst_in = b + 1; dst_h_in = b + 2; src0_in = b + 3; src1_in = b + 4;
      dst_addr = b + 'h100; dst_h_addr = b + 'h204; src0_addr = b + 'h308; src1_addr = b + 'h40c;
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) @(posedge clk);
      #2;
      vectors++;
      if ({bus_req, bus_write, bus_addr, bus_data, busy, done, err} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got req=%b we=%b addr=%h data=%h busy=%b done=%b err=%b, required all 0",
                  bus_req, bus_write, bus_addr, bus_data, busy, done, err);
      end
      rst = 0;
   endtask

   task automatic test_single();
      int lat, clks, d0;
      ack_delay = 1;
      dst_in = 32'h7;
      dst_addr = 32'h100;
      d0 = done_cnt;
      fire(4'b0001, 4'b0001);
      wait_done(lat, clks);
      vectors++;
      if (lat !== 4) begin miscompares++; $display("FAIL single_latency: got %0d, required 4", lat); end
      vectors++;
      if ({busy, err} !== 2'b10) begin miscompares++; $display("FAIL single_flags: got busy=%b err=%b, required busy=1 err=0", busy, err); end
      en_edge();
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_clear: got %b, required 0", busy); end
      vectors++;
      if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL single_done_count: got %0d, required 1", done_cnt - d0); end
      vectors++;
      if (exp_q.size() !== 0) begin miscompares++; $display("FAIL single_pending: got %0d, required 0", exp_q.size()); end
   endtask

   task automatic test_mask_1011();
      int lat, clks, d0;
      set_words(32'hA000_0000);
      d0 = done_cnt;
      fire(4'b1011, 4'b1011);
      wait_done(lat, clks);
      vectors++;
      if (lat !== 10) begin miscompares++; $display("FAIL m1011_latency: got %0d, required 10", lat); end
      vectors++;
      if (err !== 1'b0) begin miscompares++; $display("FAIL m1011_err: got %b, required 0", err); end
      en_edge();
      vectors++;
      if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL m1011_done_count: got %0d, required 1", done_cnt - d0); end
      vectors++;
      if (exp_q.size() !== 0) begin miscompares++; $display("FAIL m1011_pending: got %0d, required 0", exp_q.size()); end
   endtask

   task automatic test_bus_busy();
      int lat, clks, bad;
      set_words(32'h5000_0000);
      is_bus_busy = 1;
      fire(4'b0101, 4'b0101);
      set_words(32'hFFFF_0000);
      wr_mask = 4'b1111;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         en_edge();
         if (bus_req) bad++;
      end
      vectors++;
      if (bad !== 0) begin miscompares++; $display("FAIL busbusy_req: got %0d cycles with bus_req, required 0", bad); end
      is_bus_busy = 0;
      wait_done(lat, clks);
      vectors++;
      if (lat !== 7) begin miscompares++; $display("FAIL busbusy_latency: got %0d after release, required 7", lat); end
      en_edge();
      vectors++;
      if (exp_q.size() !== 0) begin miscompares++; $display("FAIL busbusy_pending: got %0d, required 0", exp_q.size()); end
   endtask

   task automatic test_timeout();
      int lat, clks, d0;
      set_words(32'h3000_0000);
      ack_en = 0;
      d0 = done_cnt;
      fire(4'b0011, 4'b0001);
      req_hi = 0;
      wait_done(lat, clks);
      vectors++;
      if (lat !== 6) begin miscompares++; $display("FAIL timeout_latency: got %0d, required 6", lat); end
      vectors++;
      if (err !== 1'b1) begin miscompares++; $display("FAIL timeout_err: got %b, required 1", err); end
      vectors++;
      if (req_hi !== 4) begin miscompares++; $display("FAIL timeout_hold: got %0d cycles, required 4", req_hi); end
      ack_en = 1;
      repeat (3) en_edge();
      vectors++;
      if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL timeout_done_count: got %0d, required 1", done_cnt - d0); end
      vectors++;
      if ({err, exp_q.size()} !== {1'b1, 32'd0}) begin
         miscompares++;
         $display("FAIL timeout_sticky: got err=%b pending=%0d, required err=1 pending=0", err, exp_q.size());
      end
   endtask

   task automatic test_clk_oe_toggle();
      int lat, clks, d0;
      set_words(32'h7700_0000);
      oe_tog = 1;
      d0 = done_cnt;
      fire(4'b1111, 4'b1111);
      wait_done(lat, clks);
      vectors++;
      if (lat !== 13) begin miscompares++; $display("FAIL toggle_latency: got %0d, required 13", lat); end
      vectors++;
      if (clks !== 26) begin miscompares++; $display("FAIL toggle_clocks: got %0d, required 26", clks); end
      vectors++;
      if (err !== 1'b0) begin miscompares++; $display("FAIL toggle_err: got %b, required 0", err); end
      en_edge();
      oe_tog = 0;
      en_edge();
      vectors++;
      if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL toggle_done_width: got %0d, required 1", done_cnt - d0); end
      vectors++;
      if (exp_q.size() !== 0) begin miscompares++; $display("FAIL toggle_pending: got %0d, required 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      int lat, clks, d0;
      logic found;
      set_words(32'h9900_0000);
      ack_delay = 3;
      fire(4'b1111, 4'b1111);
      found = 0;
      for (int k = 0; k < 100 && !found; k++) begin
         en_edge();
         found = bus_req && (bus_addr == dst_h_addr);
      end
      vectors++;
      if (!found) begin miscompares++; $display("FAIL rstmid_reach: got no second write, required one"); end
      d0 = done_cnt;
      rst = 1;
      @(posedge clk);
      #2;
      vectors++;
      if ({bus_req, bus_write, bus_addr, bus_data, busy, done, err} !== '0) begin
         miscompares++;
         $display("FAIL rstmid_outputs: got req=%b we=%b addr=%h data=%h busy=%b done=%b err=%b, required all 0",
                  bus_req, bus_write, bus_addr, bus_data, busy, done, err);
      end
      rst = 0;
      exp_q.delete();
      repeat (5) en_edge();
      vectors++;
      if ({done_cnt - d0, bus_req} !== {32'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL rstmid_quiet: got done=%0d req=%b, required done=0 req=0", done_cnt - d0, bus_req);
      end
      ack_delay = 1;
      fire(4'b0000, 4'b0000);
      wait_done(lat, clks);
      vectors++;
      if (lat !== 1) begin miscompares++; $display("FAIL rstmid_mask0_latency: got %0d, required 1", lat); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_mask_1011();
      test_bus_busy();
      test_timeout();
      test_clk_oe_toggle();
      test_reset_mid();
      repeat (3) en_edge();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/alu_result_writer.md
# alu_result_writer

Write-back stage directly downstream of the ALU. When the ALU finishes a command, this block latches its four result words: dst, dst_h, src0 and src1. It then writes the words selected by a mask to memory, one bus write at a time, arbitrating for the shared bus. It pulses `done` so the control unit can leave the ALU results state.

## Interface
- `DATA_W`, 32, width of each result word and of the bus data.
- `ADDR_W`, 32, bus address width.
- `ACK_TIMEOUT`, 255, maximum enabled cycles spent waiting for `bus_ack` per word before aborting.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `clk_oe` in 1: clock qualifier; the FSM advances only on posedges where `clk_oe`=1.
- `start` in 1: results valid; sampled only in IDLE.
- `wr_mask` in 4: word enables. Bit0 = dst, bit1 = dst_h, bit2 = src0, bit3 = src1.
- `dst_in`, `dst_h_in`, `src0_in`, `src1_in` in DATA_W each: ALU result words.
- `dst_addr`, `dst_h_addr`, `src0_addr`, `src1_addr` in ADDR_W each: target address for each word.
- `is_bus_busy` in 1: another master owns the bus.
- `bus_ack` in 1: the memory accepted the current write.
- `bus_req` out 1: this block owns the bus and is driving a write.
- `bus_write` out 1: write strobe.
- `bus_addr` out ADDR_W: write address.
- `bus_data` out DATA_W: write data.
- `busy` out 1: block is not idle.
- `done` out 1: completion pulse, one enabled cycle wide.
- `err` out 1: the last job aborted on timeout; sticky until the next accepted `start`.

## Operation
- States: IDLE, ARB, WRITE, DONE.
- **IDLE.** On an enabled edge with `start`=1:
  - latch all four data words, all four addresses and `wr_mask` into internal registers;
  - clear `err`;
  - set the slot pointer to the lowest set mask bit;
  - go to ARB.
  - If `wr_mask`=0, go straight to DONE instead.
- **ARB.** Wait while `is_bus_busy`=1. On an enabled edge with `is_bus_busy`=0, go to WRITE and register the bus outputs:
  - `bus_req`=1 and `bus_write`=1;
  - `bus_addr` and `bus_data` taken from the current slot.
- **WRITE.** Hold the bus outputs stable.
  - On an enabled edge with `bus_ack`=1, clear the current mask bit.
  - If bits remain, move to the next higher set bit and go to ARB; bus outputs drop to 0 for at least one enabled cycle.
  - Otherwise go to DONE.
  - The timeout counter resets on entry to WRITE and increments each enabled cycle without ack. When it reaches ACK_TIMEOUT, set `err`=1, drop the bus and go to DONE; the remaining words are discarded.
- **DONE.** `done`=1 for exactly one enabled cycle, then return to IDLE.
- Write order is always dst, dst_h, src0, src1, skipping masked-off slots.
- Input changes after the latch do not affect a job in progress.
- `start` while `busy`=1 is ignored (not queued).
- `is_bus_busy` is ignored once in WRITE; this block owns the bus until ack or timeout.

## Timing
- **Reset:**
  - applies on any posedge, regardless of `clk_oe`;
  - all outputs go to 0, state to IDLE, internal registers and timeout counter to 0;
  - a reset in the middle of a job drops the bus immediately (no partial-write completion) and emits no `done`.
- All outputs are registered. `bus_*` and `done` are forced to 0 on any edge where `clk_oe`=0, except that `bus_*` hold their values while in WRITE.
- **Minimum latency** (enabled cycles, counted from the `start` edge; `is_bus_busy`=0 and `bus_ack` returned in the cycle after WRITE is entered):
  - the first write is visible 1 cycle after `start`;
  - each word takes 3 enabled cycles (ARB, WRITE, ack);
  - `done` arrives 3·N+1 cycles after `start`, where N is the number of words written;
  - a mask of 0 gives `done` 1 cycle after `start`.
- An ack present in the same cycle that WRITE is entered is not sampled; ack is valid from the first enabled edge after WRITE is entered.
- If ack and timeout occur on the same edge, the ack wins: the word counts as written and `err` stays 0.
- `busy`=1 from the edge after `start` until the edge on which `done` falls.

## Test plan
- `wr_mask`=4'b0001, dst=0x0000_0007 to addr 0x100, ack after 1 cycle -> one write (0x100, 7); `done` pulse; `err`=0.
- `wr_mask`=4'b1011, distinct data and addresses -> writes in order dst, dst_h, src1 only; `bus_req` low for ≥1 enabled cycle between writes; exactly one `done`.
- `is_bus_busy`=1 for 10 enabled cycles after `start` -> no `bus_req` during those cycles; write proceeds after release; data equals the value latched at `start` even though the inputs changed meanwhile.
- `bus_ack` held at 0, ACK_TIMEOUT=4, `wr_mask`=4'b0011 -> bus held 4 enabled cycles, then dropped; `err`=1; `done` pulses; dst_h is never written.
- `clk_oe` toggling every cycle with a full mask -> the same write sequence as with `clk_oe`=1, taking twice the clock cycles; `done` is exactly one enabled cycle wide.
- `rst` asserted while in WRITE for the second word -> next edge: all outputs 0, IDLE, no `done`; a new `start` with `wr_mask`=0 gives `done` 1 enabled cycle later.
